// File: rtl/div_seq.sv
// Multi-cycle restoring divider for the EX stage: one quotient bit per cycle,
// signed/unsigned, divide-by-zero and flush handling, {remainder, quotient} result.
module div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               annul,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall_req
);

  typedef enum logic [1:0] {IDLE, DIVZERO, BUSY, DONE} state_t;

  localparam logic [5:0] STEPS = 6'(WIDTH);

  state_t               state, state_n;
  logic [5:0]           cnt, cnt_n;
  logic [2*WIDTH:0]     work, work_n;
  logic [WIDTH-1:0]     dvsr, dvsr_n;
  logic                 q_neg, q_neg_n;
  logic                 r_neg, r_neg_n;
  logic [2*WIDTH-1:0]   result_n;
  logic                 ready_n;

  logic [WIDTH:0]       diff;
  logic [WIDTH-1:0]     mag1, mag2;
  logic [WIDTH-1:0]     quot, rem_v;

  assign stall_req = start & ~ready & ~annul;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      work   <= '0;
      dvsr   <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      result <= '0;
      ready  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      work   <= work_n;
      dvsr   <= dvsr_n;
      q_neg  <= q_neg_n;
      r_neg  <= r_neg_n;
      result <= result_n;
      ready  <= ready_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    work_n   = work;
    dvsr_n   = dvsr;
    q_neg_n  = q_neg;
    r_neg_n  = r_neg;
    result_n = result;
    ready_n  = ready;

    mag1  = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
    mag2  = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
    diff  = work[2*WIDTH:WIDTH] - {1'b0, dvsr};
    quot  = q_neg ? -work[WIDTH-1:0] : work[WIDTH-1:0];
    rem_v = r_neg ? -work[2*WIDTH:WIDTH+1] : work[2*WIDTH:WIDTH+1];

    if (annul && state != IDLE) begin
      state_n  = IDLE;
      cnt_n    = '0;
      ready_n  = 1'b0;
      result_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !annul) begin
            cnt_n = '0;
            if (opdata2 == '0) begin
              state_n = DIVZERO;
            end else begin
              state_n = BUSY;
              // Dividend sits one bit up so each step compares before shifting.
              work_n  = {{WIDTH{1'b0}}, mag1, 1'b0};
              dvsr_n  = mag2;
              q_neg_n = signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
              r_neg_n = signed_div & opdata1[WIDTH-1];
            end
          end
        end
        DIVZERO: begin
          // First cycle clears the work register, second one signals the zero result.
          if (cnt == '0) begin
            work_n = '0;
            cnt_n  = 6'd1;
          end else begin
            cnt_n    = '0;
            result_n = '0;
            ready_n  = 1'b1;
            state_n  = DONE;
          end
        end
        BUSY: begin
          if (cnt == STEPS) begin
            result_n = {rem_v, quot};
            ready_n  = 1'b1;
            cnt_n    = '0;
            state_n  = DONE;
          end else begin
            if (diff[WIDTH])
              work_n = {work[2*WIDTH-1:0], 1'b0};
            else
              work_n = {diff[WIDTH-1:0], work[WIDTH-1:0], 1'b1};
            cnt_n = cnt + 6'd1;
          end
        end
        DONE: begin
          if (!start) begin
            state_n  = IDLE;
            ready_n  = 1'b0;
            result_n = '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: driver pushes reference results, a monitor pops
// and checks them on each ready rise, together with latency and handshake rules.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        annul;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [63:0] result;
  logic        ready;
  logic        stall_req;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] res;
    int unsigned lat;
  } exp_t;

  exp_t expq[$];

  always #5 clk = ~clk;

  div_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .annul      (annul),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .result     (result),
    .ready      (ready),
    .stall_req  (stall_req)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division, truncating toward zero.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // Monitor: samples late in each cycle, after outputs settle and before the next edge.
  logic        ready_q = 1'b0;
  int unsigned stall_cycles = 0;
  logic [63:0] held = '0;
  exp_t        e_mon;

  always @(posedge clk) begin
    #4;
    if (!rst) begin
      stall_cycles = 0;
    end else begin
      check("stall_req", {63'd0, stall_req}, {63'd0, start & ~ready & ~annul});
      if (ready && !ready_q) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: got result %h expected no response", result);
        end else begin
          e_mon = expq.pop_front();
          check("result", result, e_mon.res);
          check("latency", 64'(stall_cycles), 64'(e_mon.lat));
        end
        held = result;
        stall_cycles = 0;
      end else if (ready && ready_q) begin
        check("hold_result", result, held);
      end else if (!ready) begin
        check("idle_result", result, 64'd0);
      end
      if (annul) stall_cycles = 0;
      else if (start && !ready) stall_cycles++;
    end
    ready_q = rst ? ready : 1'b0;
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input int unsigned hold);
    exp_t e;
    int unsigned n;
    e.res = ref_div(a, b, sgn);
    e.lat = (b == 32'd0) ? 2 : 33;
    @(negedge clk);
    opdata1 = a; opdata2 = b; signed_div = sgn; start = 1'b1;
    expq.push_back(e);
    n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
      if (!ready) begin
        opdata1 = $urandom; opdata2 = $urandom; signed_div = 1'($urandom_range(0, 1));
      end
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no ready after %0d cycles expected ready", n);
    end
    repeat (hold) @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("drop_ready", {63'd0, ready}, 64'd0);
    check("drop_result", result, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b;
    int unsigned sel, n;

    rst = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    opdata1 = '0; opdata2 = '0;
    @(posedge clk); #2;
    check("reset_ready", {63'd0, ready}, 64'd0);
    check("reset_result", result, 64'd0);
    start = 1'b1; #1;
    check("reset_stall_follows_start", {63'd0, stall_req}, 64'd1);
    start = 1'b0;
    @(negedge clk); rst = 1'b1;

    run_op(32'd100, 32'd7, 1'b0, 5);
    run_op(32'hFFFFFFF9, 32'd2, 1'b1, 0);
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 0);
    run_op(32'h12345678, 32'd0, 1'b1, 1);
    run_op(32'hFFFFFFFF, 32'd1, 1'b0, 0);

    // Flush at BUSY step 10, then a fresh request.
    @(negedge clk);
    opdata1 = 32'd5000; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
    repeat (11) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    check("annul_ready", {63'd0, ready}, 64'd0);
    annul = 1'b0; start = 1'b0;
    run_op(32'd9, 32'd3, 1'b0, 0);

    // Asynchronous reset in the middle of BUSY.
    @(negedge clk);
    opdata1 = 32'd1000; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
    repeat (12) @(negedge clk);
    @(posedge clk); #3; rst = 1'b0; #1;
    check("rst_busy_ready", {63'd0, ready}, 64'd0);
    check("rst_busy_result", result, 64'd0);
    check("rst_busy_stall", {63'd0, stall_req}, 64'd1);
    @(negedge clk); start = 1'b0; rst = 1'b1;
    run_op(32'd50, 32'd5, 1'b0, 0);

    // Asynchronous reset while a result is held in DONE.
    begin
      exp_t e;
      e.res = ref_div(32'd200, 32'd9, 1'b0);
      e.lat = 33;
      @(negedge clk);
      opdata1 = 32'd200; opdata2 = 32'd9; signed_div = 1'b0; start = 1'b1;
      expq.push_back(e);
      n = 0;
      while (!ready && n < 100) begin @(negedge clk); n++; end
      if (!ready) begin
        checks++; errors++;
        $display("FAIL timeout_done_rst: got no ready expected ready");
      end
      @(posedge clk); #3; rst = 1'b0; #1;
      check("rst_done_ready", {63'd0, ready}, 64'd0);
      check("rst_done_result", result, 64'd0);
      @(negedge clk); start = 1'b0; rst = 1'b1;
    end

    for (int i = 0; i < 24; i++) begin
      a = $urandom; b = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = 32'd0;
        1: b = 32'd1;
        2: b = 32'hFFFFFFFF;
        3: b = $urandom_range(1, 255);
        4: a = 32'h80000000;
        default: ;
      endcase
      run_op(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(expq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
